// File: rtl/gameplay_pkg.sv
// -----------------------------------------------------------------------------
// gameplay_pkg
// Shared definitions for the stacking-game control FSM (gameplay_sequencer)
// and its datapath (gameplay_datapath).
//   - X_W / Y_W     : widths of the block x (8 bit) and y (7 bit) coordinates
//   - DEF_*         : default screen geometry
//   - seq_state_t   : sequencer state encoding
// -----------------------------------------------------------------------------
package gameplay_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  // Default geometry: a block spawns at the left edge (x=0) or right edge
  // (x=152); the first block sits at y=116 and each level is 4 rows higher.
  localparam logic [X_W-1:0] DEF_X_RIGHT  = 8'd152;
  localparam logic [Y_W-1:0] DEF_Y_BOTTOM = 7'd116;
  localparam logic [Y_W-1:0] DEF_Y_TOP    = 7'd4;
  localparam logic [Y_W-1:0] DEF_BLOCK_H  = 7'd4;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_SPAWN  = 4'd1,
    S_MOVE   = 4'd2,
    S_DROP   = 4'd3,
    S_WAIT   = 4'd4,
    S_JUDGE  = 4'd5,
    S_HIT    = 4'd6,
    S_MISS   = 4'd7,
    S_SETTLE = 4'd8,
    S_OVER   = 4'd9
  } seq_state_t;

endpackage

// File: rtl/gameplay_sequencer_edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for a level input (start / drop keys).
// The history register resets to 1, so a key already held while reset is
// released does not produce an edge; the key must be released and pressed
// again.
// Ports:
//   clk      in  : clock
//   resetn   in  : asynchronous active-low reset
//   i_level  in  : level input
//   o_rise   out : one-cycle pulse when i_level goes 0 -> 1
// -----------------------------------------------------------------------------
module edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/gameplay_sequencer.sv
// -----------------------------------------------------------------------------
// gameplay_sequencer
// Control FSM for gameplay_datapath. Spawns each block at the start row, lets
// it slide until the player drops it, waits out the overlap detector's
// one-cycle latency, then awards score (hit) or removes a chance (miss) and
// steps the stack height. The round ends when chances run out or the stack
// reaches the top of the screen.
//
// Optional feature (compile-time macro GAMEPLAY_SEQ_AUTODROP_EN):
//   when defined, a block left moving for DROP_TIMEOUT sync ticks is dropped
//   automatically. When undefined, MOVE waits for the player indefinitely.
//
// Parameters:
//   X_RIGHT      : spawn x when direction = 1 (direction 0 spawns at x = 0)
//   Y_BOTTOM     : y of the first (bottom) block
//   Y_TOP        : stack complete when the next y would be above this row
//   BLOCK_H      : y step per successful level
//   DROP_TIMEOUT : sync ticks before auto-drop (macro builds only)
//
// Ports:
//   clk, resetn (async, active-low)
//   start, drop        in  : key levels, rising edge acts
//   sync               in  : one-cycle movement tick
//   o, c               in  : overlap flag, chances-remaining flag
//   enable, save_x, ld_x, ld_y, ld_d, inc_score, dec_chances  out : strobes
//   new_direction, new_x_position, new_y_position             out : load data
//   playing, game_over, win                                   out : status
// -----------------------------------------------------------------------------
module gameplay_sequencer
  import gameplay_pkg::*;
#(
  parameter logic [X_W-1:0] X_RIGHT      = DEF_X_RIGHT,
  parameter logic [Y_W-1:0] Y_BOTTOM     = DEF_Y_BOTTOM,
  parameter logic [Y_W-1:0] Y_TOP        = DEF_Y_TOP,
  parameter logic [Y_W-1:0] BLOCK_H      = DEF_BLOCK_H,
  parameter logic [7:0]     DROP_TIMEOUT = 8'd200
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           drop,
  input  logic           sync,
  input  logic           o,
  input  logic           c,
  output logic           enable,
  output logic           save_x,
  output logic           ld_x,
  output logic           ld_y,
  output logic           ld_d,
  output logic           inc_score,
  output logic           dec_chances,
  output logic           new_direction,
  output logic [X_W-1:0] new_x_position,
  output logic [Y_W-1:0] new_y_position,
  output logic           playing,
  output logic           game_over,
  output logic           win
);

  seq_state_t     r_state;
  seq_state_t     w_next;

  logic           r_dir;
  logic [Y_W-1:0] r_y;
  logic           r_first;
  logic           r_win;

  logic           w_start_edge;
  logic           w_drop_edge;
  logic           w_drop_go;
  logic           w_top;

  edge_detect u_start_edge (
    .clk     (clk),
    .resetn  (resetn),
    .i_level (start),
    .o_rise  (w_start_edge)
  );

  edge_detect u_drop_edge (
    .clk     (clk),
    .resetn  (resetn),
    .i_level (drop),
    .o_rise  (w_drop_edge)
  );

`ifdef GAMEPLAY_SEQ_AUTODROP_EN
  // Counts sync ticks while the block moves; holds at DROP_TIMEOUT so the
  // timeout stays asserted until MOVE is left. A player drop in the same
  // cycle simply ORs into the same single drop request.
  logic [7:0] r_drop_cnt;
  logic       w_timeout;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_drop_cnt <= 8'd0;
    end else if (r_state == S_SPAWN) begin
      r_drop_cnt <= 8'd0;
    end else if ((r_state == S_MOVE) && sync && (r_drop_cnt != DROP_TIMEOUT)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_drop_cnt == DROP_TIMEOUT);
  assign w_drop_go = w_drop_edge | w_timeout;
`else
  logic w_unused_sync;
  assign w_unused_sync = sync;
  assign w_drop_go     = w_drop_edge;
`endif

  // Stack is complete when y_cur - BLOCK_H < Y_TOP. Evaluated as
  // y_cur < BLOCK_H + Y_TOP in 8 bits so the subtraction cannot wrap.
  assign w_top = ({1'b0, r_y} < ({1'b0, BLOCK_H} + {1'b0, Y_TOP}));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    enable         = 1'b0;
    save_x         = 1'b0;
    ld_x           = 1'b0;
    ld_y           = 1'b0;
    ld_d           = 1'b0;
    inc_score      = 1'b0;
    dec_chances    = 1'b0;
    new_direction  = 1'b0;
    new_x_position = '0;
    new_y_position = '0;
    playing        = 1'b1;
    game_over      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        playing = 1'b0;
        if (w_start_edge) begin
          w_next = S_SPAWN;
        end
      end
      S_SPAWN: begin
        ld_x           = 1'b1;
        ld_y           = 1'b1;
        ld_d           = 1'b1;
        new_direction  = r_dir;
        new_x_position = r_dir ? X_RIGHT : '0;
        new_y_position = r_y;
        w_next         = S_MOVE;
      end
      S_MOVE: begin
        enable = 1'b1;
        if (w_drop_go) begin
          w_next = S_DROP;
        end
      end
      S_DROP: begin
        w_next = S_WAIT;
      end
      // Overlap flag is registered in the datapath; give it a cycle.
      S_WAIT: begin
        w_next = S_JUDGE;
      end
      // The bottom block always counts as a hit: there is nothing below it.
      S_JUDGE: begin
        w_next = (o || r_first) ? S_HIT : S_MISS;
      end
      S_HIT: begin
        inc_score = 1'b1;
        save_x    = 1'b1;
        w_next    = w_top ? S_OVER : S_SPAWN;
      end
      S_MISS: begin
        dec_chances = 1'b1;
        w_next      = S_SETTLE;
      end
      // c reflects the decremented chances count only from this cycle on.
      S_SETTLE: begin
        w_next = c ? S_SPAWN : S_OVER;
      end
      S_OVER: begin
        playing   = 1'b0;
        game_over = 1'b1;
        if (w_start_edge) begin
          w_next = S_SPAWN;
        end
      end
      default: begin
        playing = 1'b0;
        w_next  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dir   <= 1'b0;
      r_y     <= Y_BOTTOM;
      r_first <= 1'b1;
      r_win   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start_edge) begin
            r_dir   <= 1'b0;
            r_y     <= Y_BOTTOM;
            r_first <= 1'b1;
            r_win   <= 1'b0;
          end
        end
        // Successive levels alternate the side the block enters from.
        S_HIT: begin
          r_first <= 1'b0;
          r_dir   <= ~r_dir;
          if (w_top) begin
            r_win <= 1'b1;
          end else begin
            r_y <= r_y - BLOCK_H;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign win = r_win;

endmodule
